softmax_seq_ctrl: RTL

Sequencer that feeds the N-lane Q6.10 softmax datapath from a serial 16-bit stream and returns the probabilities serially. It gathers up to N input scores into a parallel register, launches one softmax pass (valid_in pulse plus held enable), and waits for valid_out under a watchdog. It then unloads the result vector one element per handshake. It sits between an upstream producer (test FSM or host DMA) and the softmax instance, replacing ad-hoc stimulus logic.

---
 rtl/softmax_pkg.sv | 20 ++
 rtl/softmax_wdt.sv | 38 +++
 rtl/softmax_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencer slice.
// Holds the element format constants, the pad value for unused lanes and
// the controller state encoding.
package softmax_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;

    // -32.0 in Q6.10: padded lanes contribute a negligible exp() term
    localparam logic [DATA_W-1:0] PAD_VAL = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

endpackage

// File: rtl/softmax_wdt.sv
// Watchdog counter guarding the wait for the softmax result.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear of the count
//   en        - count enable (one increment per enabled cycle)
//   expire    - high while enabled and the count sits at TIMEOUT-1
// The count saturates at TIMEOUT-1 so it can never wrap back to zero.
module softmax_wdt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Saturating cycle counter, cleared whenever the controller is not waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Sequencer between a serial score stream and the N-lane softmax datapath.
// Gathers up to N scores into a parallel register (padding short frames),
// launches one softmax pass, waits for the result under a watchdog and
// streams the probabilities back out, one element per handshake.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last - input score stream
//   sm_valid_in, sm_en       - launch pulse and enable to the softmax
//   sm_in_x_flat             - parallel scores, lane k at [k*DW +: DW]
//   sm_valid_out, sm_prob_flat - softmax result strobe and vector
//   m_valid/m_ready/m_data/m_last - output probability stream
//   busy                     - controller not idle
//   err_len, err_timeout     - single-cycle error pulses
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int N       = 64,
    parameter int DW      = DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic            s_last,
    output logic            sm_valid_in,
    output logic            sm_en,
    output logic [N*DW-1:0] sm_in_x_flat,
    input  logic            sm_valid_out,
    input  logic [N*DW-1:0] sm_prob_flat,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_last,
    output logic            busy,
    output logic            err_len,
    output logic            err_timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_LANE = IW'(N - 1);
    localparam logic [DW-1:0] PAD       = DW'(PAD_VAL);

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   oidx_r;
    logic [IW-1:0]   last_idx_r;   // frame length minus one
    logic [N*DW-1:0] result_r;
    logic [IW-1:0]   nxt_oidx_s;
    logic            wdt_expire_s;
    logic            waiting_s;

    assign nxt_oidx_s = oidx_r + IW'(1);
    assign waiting_s  = (state_r == S_WAIT);

    softmax_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (!waiting_s),
        .en     (waiting_s),
        .expire (wdt_expire_s)
    );

    // Controller FSM: load, launch, wait, unload, with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            idx_r        <= {IW{1'b0}};
            oidx_r       <= {IW{1'b0}};
            last_idx_r   <= {IW{1'b0}};
            result_r     <= {(N*DW){1'b0}};
            sm_in_x_flat <= {(N*DW){1'b0}};
            s_ready      <= 1'b0;
            sm_valid_in  <= 1'b0;
            sm_en        <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= {DW{1'b0}};
            m_last       <= 1'b0;
            busy         <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            // pulse outputs default low each cycle
            sm_valid_in <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;

            case (state_r)
                S_IDLE, S_LOAD: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        sm_in_x_flat[int'(idx_r)*DW +: DW] <= s_data;
                        busy <= 1'b1;
                        if (s_last || (idx_r == LAST_LANE)) begin
                            // lanes beyond the last written one get the pad value
                            for (int k = 0; k < N; k++) begin
                                if (k > int'(idx_r)) begin
                                    sm_in_x_flat[k*DW +: DW] <= PAD;
                                end
                            end
                            last_idx_r  <= idx_r;
                            idx_r       <= {IW{1'b0}};
                            err_len     <= (idx_r == LAST_LANE) && !s_last;
                            s_ready     <= 1'b0;
                            sm_valid_in <= 1'b1;
                            sm_en       <= 1'b1;
                            state_r     <= S_LAUNCH;
                        end else begin
                            idx_r   <= idx_r + IW'(1);
                            state_r <= S_LOAD;
                        end
                    end
                end

                S_LAUNCH: begin
                    state_r <= S_WAIT;
                end

                S_WAIT: begin
                    // a result arriving on the expiry cycle still counts
                    if (sm_valid_out) begin
                        result_r <= sm_prob_flat;
                        sm_en    <= 1'b0;
                        m_valid  <= 1'b1;
                        m_data   <= sm_prob_flat[DW-1:0];
                        m_last   <= (last_idx_r == {IW{1'b0}});
                        oidx_r   <= {IW{1'b0}};
                        state_r  <= S_UNLOAD;
                    end else if (wdt_expire_s) begin
                        err_timeout <= 1'b1;
                        sm_en       <= 1'b0;
                        busy        <= 1'b0;
                        s_ready     <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end

                S_UNLOAD: begin
                    if (m_valid && m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                            state_r <= S_IDLE;
                        end else begin
                            oidx_r  <= nxt_oidx_s;
                            m_data  <= result_r[int'(nxt_oidx_s)*DW +: DW];
                            m_last  <= (nxt_oidx_s == last_idx_r);
                        end
                    end
                end

                default: begin
                    state_r     <= S_IDLE;
                    s_ready     <= 1'b0;
                    sm_en       <= 1'b0;
                    m_valid     <= 1'b0;
                    m_last      <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
